// File: rtl/uart_tx_sched.sv
// Round-robin scheduler feeding one byte per frame from four requesters to a BaudTick-clocked UART transmitter.
// A FLUSH frame after reset lets the un-resettable transmitter drain before the first start request.
module uart_tx_sched #(
  parameter int NREQ        = 4,
  parameter int FRAME_TICKS = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              BaudTick,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        TxD_data,
  output logic              TxD_start,
  output logic [1:0]        grant_id,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [2:0] {
    S_FLUSH,
    S_IDLE,
    S_LOAD,
    S_START,
    S_SEND
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  tcnt_q, tcnt_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [7:0]  data_q, data_d;
  logic [1:0]  gid_q, gid_d;
  logic        fdone_q, fdone_d;

  logic [1:0]  win;
  logic [1:0]  idx;
  logic        found;
  logic        last_tick;

  // First valid requester at or above rr_ptr, wrapping.
  always_comb begin
    win   = rr_ptr_q;
    idx   = rr_ptr_q;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (!found && req_valid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign last_tick = (tcnt_q == 4'(FRAME_TICKS - 1));

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    gid_d    = gid_q;
    fdone_d  = 1'b0;
    case (state_q)
      S_FLUSH: begin
        if (BaudTick) begin
          if (last_tick) begin
            tcnt_d  = 4'd0;
            state_d = S_IDLE;
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end
      S_IDLE: begin
        if (|req_valid) begin
          state_d  = S_LOAD;
          data_d   = req_data[{win, 3'b000} +: 8];
          gid_d    = win;
          rr_ptr_d = win + 2'd1;
        end
      end
      S_LOAD: begin
        state_d = S_START;
      end
      S_START: begin
        // The strobe that accepts the start is the frame's first tick.
        if (BaudTick) begin
          tcnt_d  = 4'd1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (BaudTick) begin
          if (last_tick) begin
            tcnt_d  = 4'd0;
            state_d = S_IDLE;
            fdone_d = 1'b1;
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = S_FLUSH;
        tcnt_d  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FLUSH;
      tcnt_q   <= 4'd0;
      rr_ptr_q <= 2'd0;
      data_q   <= 8'hFF;
      gid_q    <= 2'd0;
      fdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      gid_q    <= gid_d;
      fdone_q  <= fdone_d;
    end
  end

  assign req_ready  = (state_q == S_LOAD) ? (NREQ'(1) << gid_q) : '0;
  assign TxD_data   = data_q;
  assign TxD_start  = (state_q == S_START);
  assign grant_id   = gid_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = fdone_q;

endmodule
